ssg_bus_arbiter: RTL and testbench
==================================

# ssg_bus_arbiter

Two-master arbiter in front of the `dual_ssg` I/O bus. It lets the cartridge host bus (master 0) and the internal register-script sequencer (master 1) share the single SSG register port. One transaction runs at a time, selected by round-robin or fixed priority. A read stays open until its data returns, and a timeout stops a stalled slave from hanging either master.

## Interface
Parameters:
- FIXED_PRIORITY, 0 — 0: round-robin between masters; 1: master 0 always wins on simultaneous requests.
- TIMEOUT, 255 — cycles allowed for each wait phase (ready, then read data) before the transaction is aborted; range 1..255.

Ports:
- clk  in  1  system clock (85.90908 MHz).
- reset_n  in  1  reset; synchronous, active-low.
- mN_ioreq, mN_valid, mN_write  in  1 each (N=0,1)  master request; held stable until mN_ready.
- mN_address  in  8  register/port address.
- mN_wdata  in  8  write data.
- mN_ready  out  1  one-cycle accept pulse to master N.
- mN_rdata  out  8  read data; valid only while mN_rdata_en=1.
- mN_rdata_en  out  1  one-cycle read-data strobe.
- s_ioreq, s_valid, s_write  out  1 each  request to dual_ssg.
- s_address, s_wdata  out  8 each  request fields to dual_ssg.
- s_ready  in  1  slave accept.
- s_rdata  in  8  slave read data.
- s_rdata_en  in  1  slave read strobe.
- timeout_err  out  1  sticky flag, set on any abort; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_RDATA.
- IDLE:
  - req0 = m0_valid & m0_ioreq; req1 likewise.
  - If exactly one request is present, grant it.
  - If both are present: with FIXED_PRIORITY=1, grant master 0. With FIXED_PRIORITY=0, grant the master that was not granted last. last_grant resets to 1, so master 0 wins the first tie.
  - On grant: capture write/address/wdata into registers, record grant and last_grant, load the timer with TIMEOUT, go to ISSUE.
- ISSUE:
  - s_valid=s_ioreq=1; s_write/s_address/s_wdata come from the captured registers.
  - The timer decrements each cycle.
  - When s_ready=1: pulse mGrant_ready in the same cycle (combinational from s_ready).
    - Write: go to IDLE.
    - Read with s_rdata_en=1 in the same cycle: forward the data and go to IDLE.
    - Read otherwise: reload the timer and go to WAIT_RDATA.
- WAIT_RDATA:
  - s_valid=0 and s_ioreq=0.
  - When s_rdata_en=1: drive mGrant_rdata=s_rdata and mGrant_rdata_en=1 combinationally, then go to IDLE.
- Timeout: the timer reaches 0 while still waiting in ISSUE or WAIT_RDATA.
  - Set timeout_err and drop s_valid.
  - Pulse mGrant_ready, if not already given for this transaction.
  - For a read, also pulse mGrant_rdata_en with rdata=8'hFF.
  - Go to IDLE.
- The non-granted master's ready, rdata_en and rdata are held at 0.
- s_rdata_en arriving in IDLE or ISSUE without a pending read is ignored.
- Reset mid-transaction returns to IDLE immediately. No master pulses are produced for the aborted transfer.

## Timing
- Reset values:
  - All s_* outputs 0, all mN_* outputs 0, timeout_err 0.
  - State IDLE, last_grant 1.
- Request at IDLE in cycle N: s_valid is asserted in cycle N+1 (1-cycle grant latency).
- Write completes in the s_ready cycle; the arbiter is back in IDLE the next cycle.
- Minimum back-to-back spacing is 2 cycles per transaction (IDLE, ISSUE).
- After a master sees mN_ready, it deasserts valid the next cycle. The arbiter does not re-grant that master in the cycle immediately after its ready, since it is still in IDLE evaluation of the deasserted request.
- Timeout count: with TIMEOUT=T, abort occurs on the T-th cycle without the expected strobe, counted from entry into the wait state.
- The same request fields are held on s_* throughout ISSUE; they do not change until IDLE.

## Test plan
- Single write, m0 → (0xA0, 0x07): s_valid rises 1 cycle later; dual_ssg asserts ready; m0_ready pulses 1 cycle; s_valid low the next cycle; m1 sees no pulses.
- Single read, m1 from 0xA2: dual_ssg returns data 3 cycles after ready. m1_ready pulses, then m1_rdata_en pulses with m1_rdata equal to the value previously written.
- Simultaneous requests, round-robin: m0 write 0xA0←0x11 and m1 write 0xA0←0x22 held together. Grant order is m0, m1, m0, m1 over 4 issued transactions; a final readback returns the last-granted data.
- FIXED_PRIORITY=1: m0 and m1 both continuously requesting → m0 granted every time; m1 granted only once m0 drops valid.
- Timeout, TIMEOUT=8: s_ready stuck at 0 during an m0 read. After 8 cycles in ISSUE: m0_ready pulses, m0_rdata_en pulses with 0xFF, timeout_err=1. A subsequent normal write still completes.
- reset_n low during WAIT_RDATA: next cycle all outputs are 0 and state is IDLE. A late s_rdata_en after reset produces no mN_rdata_en.

Source files
------------

// File: rtl/ssg_bus_arbiter_if.sv
// ssg_bus_arbiter_if
//   One request/response channel of the dual_ssg I/O bus.
//   Used by ssg_bus_arbiter three times: once per master (m0, m1) and once
//   for the shared SSG register port (s).
//
//   ioreq, valid, write : request qualifiers, held until ready
//   address, wdata      : 8-bit request fields
//   ready               : one-cycle accept pulse
//   rdata, rdata_en     : read data and its one-cycle strobe
//
//   modport master : the side that issues requests
//   modport slave  : the side that accepts requests and returns data
interface ssg_bus_arbiter_if;
    logic       ioreq;
    logic       valid;
    logic       write;
    logic [7:0] address;
    logic [7:0] wdata;
    logic       ready;
    logic [7:0] rdata;
    logic       rdata_en;

    modport master (
        output ioreq, valid, write, address, wdata,
        input  ready, rdata, rdata_en
    );

    modport slave (
        input  ioreq, valid, write, address, wdata,
        output ready, rdata, rdata_en
    );
endinterface

// File: rtl/ssg_bus_arbiter.sv
// ssg_bus_arbiter
//   Shares the single dual_ssg register port between the cartridge host bus
//   (m0) and the register-script sequencer (m1). One transaction at a time;
//   round-robin or fixed-priority (m0 wins) arbitration on simultaneous
//   requests. Each wait phase (ready, then read data) is bounded by a
//   down-counting timer; an expired wait aborts the transfer, returns 8'hFF
//   for reads and sets the sticky timeout_err flag.
//
//   Ports:
//     clk          system clock
//     reset_n      synchronous active-low reset
//     m0, m1       master channels (arbiter is their slave)
//     s            channel towards dual_ssg (arbiter is its master)
//     timeout_err  sticky abort flag, cleared only by reset
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | no transfer; arbitrate between pending requests
//   ISSUE      | request presented on s_*, waiting for s.ready
//   WAIT_RDATA | read accepted, waiting for s.rdata_en
module ssg_bus_arbiter #(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ssg_bus_arbiter_if.slave      m0,
    ssg_bus_arbiter_if.slave      m1,
    ssg_bus_arbiter_if.master     s,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_RDATA = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);

    state_t     state;
    logic       grant;
    logic       last_grant;
    logic       s_req;
    logic       cap_write;
    logic [7:0] cap_address;
    logic [7:0] cap_wdata;
    logic [7:0] timer;

    logic       req0, req1, pick;
    logic       last_cycle;
    logic       issue_ack, issue_fwd, issue_to;
    logic       wait_fwd, wait_to;
    logic       ack, rd_en;
    logic [7:0] rd_data;

    always_comb begin
        req0 = m0.valid & m0.ioreq;
        req1 = m1.valid & m1.ioreq;
        if (req0 && req1)
            pick = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        else
            pick = req1;
    end

    // The timer holds the number of wait cycles left including the current
    // one, so a value of 1 means this is the last chance for the strobe.
    always_comb begin
        last_cycle = (timer == 8'd1);
        issue_ack  = (state == ISSUE) && s.ready;
        issue_fwd  = issue_ack && !cap_write && s.rdata_en;
        issue_to   = (state == ISSUE) && !s.ready && last_cycle;
        wait_fwd   = (state == WAIT_RDATA) && s.rdata_en;
        wait_to    = (state == WAIT_RDATA) && !s.rdata_en && last_cycle;
        // Gated by reset so a transfer killed by reset never pulses a master.
        ack        = reset_n && (issue_ack || issue_to);
        rd_en      = reset_n && (issue_fwd || wait_fwd || wait_to ||
                                 (issue_to && !cap_write));
        rd_data    = (issue_fwd || wait_fwd) ? s.rdata : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            s_req       <= 1'b0;
            cap_write   <= 1'b0;
            cap_address <= 8'h00;
            cap_wdata   <= 8'h00;
            timer       <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        cap_write   <= pick ? m1.write   : m0.write;
                        cap_address <= pick ? m1.address : m0.address;
                        cap_wdata   <= pick ? m1.wdata   : m0.wdata;
                        timer       <= TIMER_LOAD;
                        s_req       <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= timer - 8'd1;
                    if (s.ready) begin
                        s_req <= 1'b0;
                        if (cap_write || s.rdata_en) begin
                            state <= IDLE;
                        end else begin
                            timer <= TIMER_LOAD;
                            state <= WAIT_RDATA;
                        end
                    end else if (last_cycle) begin
                        s_req       <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WAIT_RDATA: begin
                    timer <= timer - 8'd1;
                    if (s.rdata_en) begin
                        state <= IDLE;
                    end else if (last_cycle) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s.ioreq   = s_req;
    assign s.valid   = s_req;
    assign s.write   = cap_write;
    assign s.address = cap_address;
    assign s.wdata   = cap_wdata;

    assign m0.ready    = ack & ~grant;
    assign m1.ready    = ack &  grant;
    assign m0.rdata_en = rd_en & ~grant;
    assign m1.rdata_en = rd_en &  grant;
    assign m0.rdata    = (rd_en && !grant) ? rd_data : 8'h00;
    assign m1.rdata    = (rd_en &&  grant) ? rd_data : 8'h00;

endmodule

// File: tb/tb_ssg_bus_arbiter.sv
// tb_ssg_bus_arbiter
//   Directed bench for ssg_bus_arbiter. Two instances: rr (round-robin,
//   TIMEOUT=8) and fp (fixed priority, TIMEOUT=8). Inputs change 1 ns after
//   the rising edge, outputs are checked on the falling edge.
module tb_ssg_bus_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rr_terr, fp_terr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ssg_mem [256];

    ssg_bus_arbiter_if rr_m0 ();
    ssg_bus_arbiter_if rr_m1 ();
    ssg_bus_arbiter_if rr_s  ();
    ssg_bus_arbiter_if fp_m0 ();
    ssg_bus_arbiter_if fp_m1 ();
    ssg_bus_arbiter_if fp_s  ();

    always #5 clk = ~clk;

    ssg_bus_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .m0(rr_m0.slave), .m1(rr_m1.slave), .s(rr_s.master),
        .timeout_err(rr_terr)
    );

    ssg_bus_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT(8)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .m0(fp_m0.slave), .m1(fp_m1.slave), .s(fp_s.master),
        .timeout_err(fp_terr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input bit v, input bit wr,
                         input logic [7:0] a, input logic [7:0] d);
        if (m == 0) begin
            rr_m0.valid = v; rr_m0.ioreq = v; rr_m0.write = wr;
            rr_m0.address = a; rr_m0.wdata = d;
        end else begin
            rr_m1.valid = v; rr_m1.ioreq = v; rr_m1.write = wr;
            rr_m1.address = a; rr_m1.wdata = d;
        end
    endtask

    function automatic logic rdy(input int m);
        return (m == 0) ? rr_m0.ready : rr_m1.ready;
    endfunction

    function automatic logic rden(input int m);
        return (m == 0) ? rr_m0.rdata_en : rr_m1.rdata_en;
    endfunction

    function automatic logic [7:0] rdat(input int m);
        return (m == 0) ? rr_m0.rdata : rr_m1.rdata;
    endfunction

    // One transaction on the rr instance. rdy_dly: ISSUE cycles before
    // s.ready; data_dly: cycles from ready to s.rdata_en (0 = same cycle).
    task automatic rr_txn(input string tag, input int m, input bit wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input int rdy_dly, input int data_dly,
                          input logic [7:0] exp_rd);
        logic [7:0] ra;
        int o;
        o = 1 - m;
        step();
        set_m(m, 1'b1, wr, a, d);
        @(negedge clk);
        chk({tag, "_grant_latency"}, rr_s.valid, 0);
        step();
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            chk({tag, "_hold_addr"}, rr_s.address, a);
            chk({tag, "_no_early_ready"}, rdy(m), 0);
            step();
        end
        rr_s.ready = 1'b1;
        ra = rr_s.address;
        if (!wr && data_dly == 0) begin
            rr_s.rdata_en = 1'b1;
            rr_s.rdata    = ssg_mem[ra];
        end
        @(negedge clk);
        chk({tag, "_s_valid"}, rr_s.valid, 1);
        chk({tag, "_s_ioreq"}, rr_s.ioreq, 1);
        chk({tag, "_s_addr"}, rr_s.address, a);
        chk({tag, "_s_write"}, rr_s.write, wr);
        if (wr) chk({tag, "_s_wdata"}, rr_s.wdata, d);
        chk({tag, "_ready"}, rdy(m), 1);
        chk({tag, "_other_ready"}, rdy(o), 0);
        if (wr) ssg_mem[ra] = rr_s.wdata;
        if (!wr && data_dly == 0) begin
            chk({tag, "_rden_fwd"}, rden(m), 1);
            chk({tag, "_rdata_fwd"}, rdat(m), exp_rd);
            chk({tag, "_other_rden"}, rden(o), 0);
        end
        step();
        rr_s.ready = 1'b0;
        rr_s.rdata_en = 1'b0;
        rr_s.rdata = 8'h00;
        set_m(m, 1'b0, 1'b0, 8'h00, 8'h00);
        if (!wr && data_dly > 0) begin
            for (int i = 1; i < data_dly; i++) begin
                @(negedge clk);
                chk({tag, "_wait_s_valid"}, rr_s.valid, 0);
                chk({tag, "_wait_no_rden"}, rden(m), 0);
                step();
            end
            rr_s.rdata_en = 1'b1;
            rr_s.rdata    = ssg_mem[ra];
            @(negedge clk);
            chk({tag, "_rden"}, rden(m), 1);
            chk({tag, "_rdata"}, rdat(m), exp_rd);
            chk({tag, "_no_second_ready"}, rdy(m), 0);
            chk({tag, "_other_rden"}, rden(o), 0);
            chk({tag, "_other_rdata"}, rdat(o), 0);
            step();
            rr_s.rdata_en = 1'b0;
            rr_s.rdata = 8'h00;
        end
        @(negedge clk);
        chk({tag, "_idle_s_valid"}, rr_s.valid, 0);
        chk({tag, "_idle_ready"}, rdy(m), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ssg_mem[i] = 8'h00;
        set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
        rr_s.ready = 1'b0; rr_s.rdata = 8'h00; rr_s.rdata_en = 1'b0;
        fp_m0.valid = 1'b0; fp_m0.ioreq = 1'b0; fp_m0.write = 1'b0;
        fp_m0.address = 8'h00; fp_m0.wdata = 8'h00;
        fp_m1.valid = 1'b0; fp_m1.ioreq = 1'b0; fp_m1.write = 1'b0;
        fp_m1.address = 8'h00; fp_m1.wdata = 8'h00;
        fp_s.ready = 1'b0; fp_s.rdata = 8'h00; fp_s.rdata_en = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_s_valid", rr_s.valid, 0);
        chk("rst_s_ioreq", rr_s.ioreq, 0);
        chk("rst_s_write", rr_s.write, 0);
        chk("rst_s_addr", rr_s.address, 0);
        chk("rst_s_wdata", rr_s.wdata, 0);
        chk("rst_m0_ready", rr_m0.ready, 0);
        chk("rst_m1_ready", rr_m1.ready, 0);
        chk("rst_m0_rden", rr_m0.rdata_en, 0);
        chk("rst_terr", rr_terr, 0);
        chk("rst_fp_s_valid", fp_s.valid, 0);
        step();
        reset_n = 1'b1;

        // Single write m0, one ISSUE cycle before ready
        rr_txn("wr_m0", 0, 1'b1, 8'hA0, 8'h07, 1, 0, 8'h00);
        // m1 write then read with data 3 cycles after ready
        rr_txn("wr_m1", 1, 1'b1, 8'hA2, 8'h5C, 0, 0, 8'h00);
        rr_txn("rd_m1", 1, 1'b0, 8'hA2, 8'h00, 0, 3, 8'h5C);

        // Round-robin: both held, last grant was m1 -> m0, m1, m0, m1
        step();
        set_m(0, 1'b1, 1'b1, 8'hA0, 8'h11);
        set_m(1, 1'b1, 1'b1, 8'hA0, 8'h22);
        @(negedge clk);
        chk("rr_first_idle", rr_s.valid, 0);
        for (int t = 0; t < 4; t++) begin
            step();
            rr_s.ready = 1'b1;
            @(negedge clk);
            chk("rr_m0_ready", rr_m0.ready, (t % 2 == 0) ? 1 : 0);
            chk("rr_m1_ready", rr_m1.ready, (t % 2 == 1) ? 1 : 0);
            chk("rr_wdata", rr_s.wdata, (t % 2 == 0) ? 8'h11 : 8'h22);
            ssg_mem[rr_s.address] = rr_s.wdata;
            step();
            rr_s.ready = 1'b0;
            if (t == 3) begin
                set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
                set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            @(negedge clk);
            chk("rr_idle_between", rr_s.valid, 0);
        end
        // Readback returns last-granted data, forwarded in the ready cycle
        rr_txn("rr_readback", 0, 1'b0, 8'hA0, 8'h00, 0, 0, 8'h22);

        // Stray s.rdata_en in IDLE is ignored
        step();
        rr_s.rdata_en = 1'b1;
        rr_s.rdata = 8'h3C;
        @(negedge clk);
        chk("stray_rden_m0", rr_m0.rdata_en, 0);
        chk("stray_rden_m1", rr_m1.rdata_en, 0);
        chk("stray_rdata_m0", rr_m0.rdata, 0);
        step();
        rr_s.rdata_en = 1'b0;
        rr_s.rdata = 8'h00;

        // Timeout in ISSUE: m0 read, s.ready stuck low, abort on 8th cycle
        set_m(0, 1'b1, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        chk("to_grant_latency", rr_s.valid, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            chk("to_s_valid", rr_s.valid, 1);
            chk("to_terr_pending", rr_terr, 0);
            chk("to_m0_ready", rr_m0.ready, (k == 8) ? 1 : 0);
            chk("to_m0_rden", rr_m0.rdata_en, (k == 8) ? 1 : 0);
            chk("to_m0_rdata", rr_m0.rdata, (k == 8) ? 8'hFF : 8'h00);
            chk("to_m1_ready", rr_m1.ready, 0);
        end
        step();
        set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("to_terr_set", rr_terr, 1);
        chk("to_s_dropped", rr_s.valid, 0);
        chk("to_m0_ready_after", rr_m0.ready, 0);

        // Normal write still completes after a timeout
        rr_txn("post_to_wr", 1, 1'b1, 8'h31, 8'h99, 0, 0, 8'h00);
        chk("terr_sticky", rr_terr, 1);

        // Timeout in WAIT_RDATA: ready given, data never returns
        step();
        set_m(1, 1'b1, 1'b0, 8'h31, 8'h00);
        step();
        rr_s.ready = 1'b1;
        @(negedge clk);
        chk("wto_m1_ready", rr_m1.ready, 1);
        chk("wto_m1_rden_early", rr_m1.rdata_en, 0);
        step();
        rr_s.ready = 1'b0;
        set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("wto_m1_rden", rr_m1.rdata_en, (k == 8) ? 1 : 0);
            chk("wto_m1_rdata", rr_m1.rdata, (k == 8) ? 8'hFF : 8'h00);
            chk("wto_m1_no_ready", rr_m1.ready, 0);
            step();
        end
        @(negedge clk);
        chk("wto_idle_rden", rr_m1.rdata_en, 0);
        chk("wto_idle_s_valid", rr_s.valid, 0);

        // Reset during WAIT_RDATA
        step();
        set_m(0, 1'b1, 1'b0, 8'h40, 8'h00);
        step();
        rr_s.ready = 1'b1;
        @(negedge clk);
        chk("rst_wait_ready", rr_m0.ready, 1);
        step();
        rr_s.ready = 1'b0;
        set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rst_wait_entered", rr_s.valid, 0);
        step();
        reset_n = 1'b0;
        rr_s.rdata_en = 1'b1;
        rr_s.rdata = 8'h55;
        @(negedge clk);
        chk("rst_during_rden", rr_m0.rdata_en, 0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_after_late_rden", rr_m0.rdata_en, 0);
        chk("rst_after_rdata", rr_m0.rdata, 0);
        chk("rst_after_ready", rr_m0.ready, 0);
        chk("rst_after_s_valid", rr_s.valid, 0);
        chk("rst_after_terr", rr_terr, 0);
        chk("rst_after_addr", rr_s.address, 0);
        step();
        rr_s.rdata_en = 1'b0;
        rr_s.rdata = 8'h00;

        // Fixed priority: both held, m0 wins three times, then m1
        fp_m0.valid = 1'b1; fp_m0.ioreq = 1'b1; fp_m0.write = 1'b1;
        fp_m0.address = 8'h50; fp_m0.wdata = 8'hAA;
        fp_m1.valid = 1'b1; fp_m1.ioreq = 1'b1; fp_m1.write = 1'b1;
        fp_m1.address = 8'h51; fp_m1.wdata = 8'hBB;
        @(negedge clk);
        chk("fp_first_idle", fp_s.valid, 0);
        for (int t = 0; t < 3; t++) begin
            step();
            fp_s.ready = 1'b1;
            @(negedge clk);
            chk("fp_m0_ready", fp_m0.ready, 1);
            chk("fp_m1_ready", fp_m1.ready, 0);
            chk("fp_addr", fp_s.address, 8'h50);
            step();
            fp_s.ready = 1'b0;
            if (t == 2) begin
                fp_m0.valid = 1'b0; fp_m0.ioreq = 1'b0;
            end
            @(negedge clk);
            chk("fp_idle_between", fp_s.valid, 0);
        end
        step();
        fp_s.ready = 1'b1;
        @(negedge clk);
        chk("fp_m1_granted", fp_m1.ready, 1);
        chk("fp_m0_not_granted", fp_m0.ready, 0);
        chk("fp_m1_addr", fp_s.address, 8'h51);
        chk("fp_m1_wdata", fp_s.wdata, 8'hBB);
        step();
        fp_s.ready = 1'b0;
        fp_m1.valid = 1'b0; fp_m1.ioreq = 1'b0;
        @(negedge clk);
        chk("fp_final_idle", fp_s.valid, 0);
        chk("fp_terr", fp_terr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
